// File: rtl/uart_tx_scheduler.sv
// UART transmit sequencer: frames bytes as start, data (LSB first), optional
// even parity and stop bits. It advances on the oversampling tick and keeps one
// byte in a holding register so the host can queue the next write.
module uart_tx_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_ENABLE,
  input  logic                  Tx_EN,
  input  logic                  Tx_WR,
  input  logic [DATA_WIDTH-1:0] Tx_DATA,
  output logic                  TxD,
  output logic                  Tx_BUSY,
  output logic                  Tx_READY,
  output logic                  Tx_DONE,
  output logic                  Tx_OVF
);

  localparam int TICK_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                r_state;
  state_t                w_state_n;
  logic [TICK_W-1:0]     r_tick;
  logic [TICK_W-1:0]     w_tick_n;
  logic [BIT_W-1:0]      r_bit;
  logic [BIT_W-1:0]      w_bit_n;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_n;
  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_hold_full;
  logic                  r_par;
  logic                  w_par_n;
  logic                  r_txd;
  logic                  w_txd_n;
  logic                  r_done;
  logic                  w_done_n;
  logic                  r_ovf;
  logic                  w_ovf_n;
  logic                  w_adv;
  logic                  w_load;
  logic                  w_accept;

  function automatic logic f_even_parity(input logic [DATA_WIDTH-1:0] d);
    return ^d;
  endfunction

  // Next-state, bit/tick bookkeeping and the registered line value
  always_comb begin
    w_state_n = r_state;
    w_tick_n  = r_tick;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_load    = 1'b0;
    w_done_n  = 1'b0;
    w_txd_n   = 1'b1;
    w_adv     = sample_ENABLE && (r_tick == TICK_MAX);

    if (r_state != S_IDLE && sample_ENABLE) begin
      w_tick_n = w_adv ? '0 : r_tick + 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (r_hold_full && Tx_EN) w_load = 1'b1;
      end
      S_START: begin
        if (w_adv) w_state_n = S_DATA;
      end
      S_DATA: begin
        if (w_adv) begin
          w_shift_n = r_shift >> 1;
          if (r_bit == BIT_LAST) begin
            w_bit_n   = '0;
            w_state_n = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            w_bit_n = r_bit + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (w_adv) w_state_n = S_STOP;
      end
      S_STOP: begin
        if (w_adv) begin
          w_done_n = 1'b1;
          if (r_hold_full && Tx_EN) w_load = 1'b1;
          else                      w_state_n = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    // Loading the held byte restarts the frame regardless of where we came from
    if (w_load) begin
      w_state_n = S_START;
      w_shift_n = r_hold;
      w_tick_n  = '0;
      w_bit_n   = '0;
    end

    w_par_n  = w_load ? f_even_parity(r_hold) : r_par;
    w_accept = Tx_WR && Tx_EN && (!r_hold_full || w_load);
    w_ovf_n  = Tx_WR && Tx_EN && r_hold_full && !w_load;

    case (w_state_n)
      S_START:  w_txd_n = 1'b0;
      S_DATA:   w_txd_n = w_shift_n[0];
      S_PARITY: w_txd_n = w_par_n;
      default:  w_txd_n = 1'b1;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_n;
  end

  // Datapath, holding register and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick      <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_par       <= 1'b0;
      r_txd       <= 1'b1;
      r_done      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_tick  <= w_tick_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
      r_par   <= w_par_n;
      r_txd   <= w_txd_n;
      r_done  <= w_done_n;
      r_ovf   <= w_ovf_n;
      if (w_accept) begin
        r_hold      <= Tx_DATA;
        r_hold_full <= 1'b1;
      end else if (w_load) begin
        r_hold_full <= 1'b0;
      end
    end
  end

  assign TxD      = r_txd;
  assign Tx_BUSY  = (r_state != S_IDLE);
  assign Tx_READY = !r_hold_full;
  assign Tx_DONE  = r_done;
  assign Tx_OVF   = r_ovf;

endmodule
